// File: rtl/uart_pkg.sv
// Shared UART types and helpers: entry layout, output-stage states, parity.
package uart_pkg;

  localparam int FIFO_DEPTH = 16;
  localparam int DATA_W     = 32;

  // One buffered word with the parity bit computed when it was written.
  typedef struct packed {
    logic              parity;
    logic [DATA_W-1:0] data;
  } tx_entry_t;

  // Output-stage state of the transmit FIFO.
  typedef enum logic {
    OS_EMPTY  = 1'b0,
    OS_LOADED = 1'b1
  } out_state_t;

  // Even parity is the XOR of all bits; odd parity is its inverse.
  // The receiver's parity checker calls this as well.
  function automatic logic calc_parity(input logic [DATA_W-1:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/fifo_mem_1r1w.sv
// DEPTH x W storage array: synchronous write port and asynchronous read port.
// Contents are not reset.
module fifo_mem_1r1w #(
  parameter int DEPTH = 16,
  parameter int W     = 33,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  // Write port: one entry per cycle on the rising edge.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_tx.sv
// UART transmit FIFO: parity tagged at write time, registered first-word
// fall-through head presented to the shifter over valid/ready, level flags
// and a sticky overflow flag for the interrupt logic.
// DATA_W must match the package width since the entry type is shared.
module fifo_tx #(
  parameter int DATA_W = uart_pkg::DATA_W,
  parameter int DEPTH  = uart_pkg::FIFO_DEPTH,
  parameter int THRESH = 2,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] Data_in,
  input  logic              parity_en,
  input  logic              parity_odd,
  input  logic              flush,
  input  logic              ovf_clr,
  input  logic              tx_ready,
  output logic              tx_valid,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_parity,
  output logic              Empty,
  output logic              Full,
  output logic              fifo_threshold,
  output logic              overflow,
  output logic [CW-1:0]     count
);

  import uart_pkg::*;

  localparam int            EW       = $bits(tx_entry_t);
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] THRESH_C = CW'(THRESH);
  localparam logic [CW-1:0] ONE_C    = CW'(1);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);

  logic [PW-1:0] wptr, rptr, raddr;
  logic          pop, wr_acc, ovf_evt, mem_we;
  tx_entry_t     wr_entry, rd_entry;
  logic [EW-1:0] rd_bits;
  out_state_t    out_state;

  // Level flags straight from the occupancy counter.
  assign Empty          = (count == '0);
  assign Full           = (count == DEPTH_C);
  assign fifo_threshold = (count <= THRESH_C);

  // A full FIFO still takes a write when the head leaves in the same cycle.
  assign pop     = tx_valid & tx_ready;
  assign wr_acc  = wr_en & (~Full | pop);
  assign ovf_evt = wr_en & Full & ~pop;
  assign mem_we  = wr_acc & ~flush & ~reset;

  // Entry built at write time; parity bit is 0 when parity is disabled.
  always_comb begin
    wr_entry.data   = Data_in;
    wr_entry.parity = parity_en ? calc_parity(Data_in, parity_odd) : 1'b0;
  end

  // On a pop the output register needs the entry behind the head.
  assign raddr    = pop ? (rptr + PTR_ONE) : rptr;
  assign rd_entry = tx_entry_t'(rd_bits);

  fifo_mem_1r1w #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (wptr),
    .wdata (EW'(wr_entry)),
    .raddr (raddr),
    .rdata (rd_bits)
  );

  // Pointers, occupancy and the sticky overflow flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      // A new overflow beats a clear in the same cycle; flush keeps the flag.
      if (ovf_evt)      overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;

      if (flush) begin
        wptr  <= '0;
        rptr  <= '0;
        count <= '0;
      end else begin
        if (wr_acc) wptr <= wptr + PTR_ONE;
        if (pop)    rptr <= rptr + PTR_ONE;
        unique case ({wr_acc, pop})
          2'b10:   count <= count + ONE_C;
          2'b01:   count <= count - ONE_C;
          default: count <= count;
        endcase
      end
    end
  end

  // Output-stage FSM: loads the head register, refills it after each pop.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      out_state <= OS_EMPTY;
      tx_valid  <= 1'b0;
      tx_data   <= '0;
      tx_parity <= 1'b0;
    end else begin
      unique case (out_state)
        OS_EMPTY: begin
          // Entry written last cycle is now readable at rptr.
          if (count != '0) begin
            out_state <= OS_LOADED;
            tx_valid  <= 1'b1;
            tx_data   <= rd_entry.data;
            tx_parity <= rd_entry.parity;
          end
        end
        OS_LOADED: begin
          if (pop) begin
            if (count >= CW'(2)) begin
              tx_data   <= rd_entry.data;
              tx_parity <= rd_entry.parity;
            end else if (wr_acc) begin
              // Last entry leaves while a new one lands behind it:
              // forward the write data so the stream has no bubble.
              tx_data   <= wr_entry.data;
              tx_parity <= wr_entry.parity;
            end else begin
              out_state <= OS_EMPTY;
              tx_valid  <= 1'b0;
            end
          end
        end
        default: begin
          out_state <= OS_EMPTY;
          tx_valid  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/fifo_tx.md
Name: fifo_tx

Overview:
- Transmit-side buffer of the UART: it sits between the host/bus write path and the UART transmitter shifter.
- The host pushes words; the block stores each word with a parity bit computed at write time.
- It presents the oldest entry to the transmitter over a valid/ready handshake.
- It raises level flags (empty, full, almost-empty threshold) and a sticky overflow error for the interrupt logic.

Parameters:
- DATA_W, 32, width of one data word.
- DEPTH, 16, number of entries (power of two, at least 4).
- THRESH, 2, almost-empty level; fifo_threshold is asserted when count <= THRESH.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- wr_en  in  1  host write strobe, one entry per cycle.
- Data_in  in  DATA_W  write data, sampled when wr_en=1.
- parity_en  in  1  1 = compute parity at write; 0 = stored parity bit forced to 0.
- parity_odd  in  1  1 = odd parity, 0 = even; sampled with wr_en.
- flush  in  1  synchronous discard of all entries.
- ovf_clr  in  1  clears the sticky overflow flag.
- tx_ready  in  1  transmitter can accept the head entry.
- tx_valid  out  1  head entry available.
- tx_data  out  DATA_W  head entry data.
- tx_parity  out  1  head entry parity bit.
- Empty  out  1  count == 0.
- Full  out  1  count == DEPTH.
- fifo_threshold  out  1  count <= THRESH (refill request; asserted while Empty too).
- overflow  out  1  sticky: a write was attempted while Full.
- count  out  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- Reset and flush (synchronous, reset wins over everything):
  - reset: wptr=0, rptr=0, count=0, overflow=0, tx_valid=0, tx_data=0, tx_parity=0.
  - Flags after reset: Empty=1, Full=0, fifo_threshold=1.
  - Memory contents are not reset.
  - flush: same as reset but does not clear overflow.
  - flush has priority over wr_en and pop in the same cycle.
- Write:
  - A write is accepted when wr_en=1 and either Full=0, or Full=1 with a pop in the same cycle.
  - An accepted write stores {parity, Data_in} at mem[wptr], and wptr increments modulo DEPTH (natural wrap).
  - Parity is the XOR-reduce of Data_in, inverted when parity_odd=1; it is 0 when parity_en=0.
  - wr_en=1 with Full=1 and no pop: data is dropped, pointers are unchanged, overflow is set to 1 on the next edge.
- Pop:
  - A pop occurs when tx_valid=1 and tx_ready=1; rptr then increments modulo DEPTH.
  - tx_ready is ignored while tx_valid=0.
- Output stage (first-word fall-through):
  - tx_valid/tx_data/tx_parity are registered.
  - A write into an empty FIFO at edge N gives tx_valid=1 with that data after edge N+1 (latency 1).
  - After a pop, the next entry is presented on the following edge with no bubble when count >= 2.
  - tx_data and tx_parity stay stable while tx_valid=1 and tx_ready=0.
  - Output-stage FSM:
    - EMPTY -> LOADED on count going 0 -> >0.
    - LOADED -> LOADED on pop with remaining entries.
    - LOADED -> EMPTY on pop of the last entry.
    - Any state -> EMPTY on flush or reset.
- Count:
  - count +1 on write only, -1 on pop only, unchanged on both or neither.
  - count never exceeds DEPTH and never goes below 0.
- Flags are combinational from count.
- overflow is cleared by ovf_clr=1. If ovf_clr and a new overflow occur in the same cycle, set wins.
- Pointers are $clog2(DEPTH) bits; Full and Empty are distinguished by count, never by pointer equality alone.

Decomposition:
- uart_pkg holds:
  - the FIFO_DEPTH and DATA_W defaults;
  - typedef tx_entry_t = packed struct {logic parity; logic [DATA_W-1:0] data;};
  - the function calc_parity(data, odd), shared with the receiver's parity checker.
- One sub-module, fifo_mem_1r1w: DEPTH x entry storage with a synchronous write port and an asynchronous read port.
- Pointers, count, FSM and flags live in fifo_tx.

Test Plan:
- Reset, then write 0xA5 with parity_en=1, parity_odd=0, tx_ready=0 -> next cycle tx_valid=1, tx_data=0xA5, tx_parity=0, count=1, Empty=0, fifo_threshold=1.
- Write 16 words 0..15 with tx_ready=0 -> Full=1, count=16. A 17th write of 0xFF -> dropped, overflow=1. Then tx_ready=1 for 16 cycles -> tx_data = 0..15 in order, no bubbles, Empty=1 afterwards.
- Full FIFO, wr_en=1 and tx_ready=1 in the same cycle -> write accepted, count stays 16, overflow stays 0. The written word emerges 16th in order after the wrap-around of wptr.
- Write 3 entries, then sweep the threshold -> fifo_threshold=0 at count=3, becomes 1 after one pop (count=2). ovf_clr pulse -> overflow returns to 0.
- Write 5 entries, assert flush while tx_ready=1 -> next cycle count=0, tx_valid=0, Empty=1, and no pop is counted. Then assert reset mid-stream after 4 writes -> all outputs at reset values on the following cycle.
- Data 0x00000001 with parity_odd=1 -> tx_parity=0. Same data with parity_odd=0 -> tx_parity=1. parity_en=0 -> tx_parity=0.
